ifetch: RTL and testbench

//  Instruction fetch stage directly upstream of maindec: owns the PC and drives imem with a req/ready handshake.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ifetch_flopenrc.sv | 29 ++
 rtl/ifetch.sv | 170 +++++++++++++++++
 tb/tb_ifetch.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding and opcodes seen by maindec.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // sll $0,$0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    // Opcode field instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // FETCH issues requests; HOLD parks one accepted word in the skid buffer
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_flopenrc.sv
// Register with async reset, synchronous clear (wins over enable) and load enable.
module flopenrc #(
    parameter int unsigned  W    = 32,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear and reset both return the register to INIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= INIT;
        end else if (i_clr) begin
            r_q <= INIT;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, imem req/ready handshake, one-entry skid buffer and IF/ID register.
module ifetch
    import cpu_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] NOP      = N'(NOP_INSTR)
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [N-1:0] imem_rdata,
    input  logic         stall_d,
    input  logic         flush_d,
    input  logic         pcsrc,
    input  logic [N-1:0] pcbranch,
    input  logic         jump,
    input  logic [N-1:0] pcjump,
    output logic [N-1:0] pc,
    output logic [N-1:0] instr_d,
    output logic [N-1:0] pcplus4_d,
    output logic         valid_d
);

    // IF/ID and skid entries are packed as {instr, pcplus4, valid}
    localparam int unsigned ENT_W = 2 * N + 1;
    localparam logic [ENT_W-1:0] IFID_INIT = {NOP, {N{1'b0}}, 1'b0};
    localparam logic [ENT_W-1:0] BUF_INIT  = '0;

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [N-1:0]     r_pc;
    logic [N-1:0]     w_pc_next;
    logic [N-1:0]     w_pcplus4;
    logic [N-1:0]     w_target;
    logic             w_pc_en;
    logic             w_accept;
    logic             w_redirect;
    logic             w_stall;

    logic [ENT_W-1:0] r_ifid;
    logic [ENT_W-1:0] w_ifid_d;
    logic             w_ifid_en;
    logic             w_ifid_clr;

    logic [ENT_W-1:0] r_buf;
    logic [ENT_W-1:0] w_buf_d;
    logic             w_buf_en;
    logic             w_buf_clr;

    assign w_accept   = (r_state == FETCH) && imem_ready;
    assign w_redirect = jump | pcsrc;
    assign w_target   = jump ? pcjump : pcbranch;
    assign w_pcplus4  = r_pc + N'(4);
    // A flush lets the pipe drain as if decode were ready
    assign w_stall    = stall_d & ~flush_d;
    assign w_buf_d    = {imem_rdata, w_pcplus4, 1'b1};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a redirect always restarts fetching
    always_comb begin
        w_state_next = r_state;
        if (w_redirect) begin
            w_state_next = FETCH;
        end else begin
            case (r_state)
                FETCH:   if (w_accept && w_stall) w_state_next = HOLD;
                HOLD:    if (!w_stall)            w_state_next = FETCH;
                default: w_state_next = FETCH;
            endcase
        end
    end

    // Output and datapath control: redirect > flush > stall > normal
    always_comb begin
        imem_req   = 1'b0;
        w_pc_en    = 1'b0;
        w_pc_next  = w_pcplus4;
        w_ifid_en  = 1'b0;
        w_ifid_clr = 1'b0;
        w_ifid_d   = {imem_rdata, w_pcplus4, 1'b1};
        w_buf_en   = 1'b0;
        w_buf_clr  = 1'b0;

        if (!reset && (r_state == FETCH)) begin
            imem_req = 1'b1;
        end

        if (w_redirect) begin
            // Wrong-path word (if any) is dropped along with the skid entry
            w_pc_en    = 1'b1;
            w_pc_next  = w_target;
            w_ifid_clr = 1'b1;
            w_buf_clr  = 1'b1;
        end else begin
            w_ifid_clr = flush_d;
            case (r_state)
                FETCH: begin
                    if (w_accept) begin
                        w_pc_en = 1'b1;
                        if (w_stall) begin
                            w_buf_en = 1'b1;
                        end else begin
                            w_ifid_en = 1'b1;
                        end
                    end else if (!w_stall) begin
                        // No word this cycle: bubble into decode
                        w_ifid_clr = 1'b1;
                    end
                end
                HOLD: begin
                    if (!w_stall) begin
                        w_ifid_en = 1'b1;
                        w_ifid_d  = r_buf;
                        w_buf_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Program counter
    flopenrc #(.W(N), .INIT(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_pc_en),
        .i_clr (1'b0),
        .i_d   (w_pc_next),
        .o_q   (r_pc)
    );

    // IF/ID pipeline register
    flopenrc #(.W(ENT_W), .INIT(IFID_INIT)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_ifid_en),
        .i_clr (w_ifid_clr),
        .i_d   (w_ifid_d),
        .o_q   (r_ifid)
    );

    // Skid buffer for a word accepted while decode is stalled
    flopenrc #(.W(ENT_W), .INIT(BUF_INIT)) u_buf (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_buf_en),
        .i_clr (w_buf_clr),
        .i_d   (w_buf_d),
        .o_q   (r_buf)
    );

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign instr_d   = r_ifid[2*N:N+1];
    assign pcplus4_d = r_ifid[N:1];
    assign valid_d   = r_ifid[0];

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios plus randomized run against a behavioural model.
module tb_ifetch;
    import cpu_pkg::*;

    localparam int unsigned N = 32;
    localparam logic [N-1:0] NOPW = NOP_INSTR;

    logic         clk = 1'b0;
    logic         reset;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ready;
    logic [N-1:0] imem_rdata;
    logic         stall_d;
    logic         flush_d;
    logic         pcsrc;
    logic [N-1:0] pcbranch;
    logic         jump;
    logic [N-1:0] pcjump;
    logic [N-1:0] pc;
    logic [N-1:0] instr_d;
    logic [N-1:0] pcplus4_d;
    logic         valid_d;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: fetch address, what decode holds, and an optional parked word
    logic [N-1:0] m_pc, m_instr, m_pc4, m_bi, m_bp;
    logic         m_valid, m_hold;

    ifetch #(.N(N), .RESET_PC(32'h0), .NOP(NOPW)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall_d(stall_d), .flush_d(flush_d),
        .pcsrc(pcsrc), .pcbranch(pcbranch),
        .jump(jump), .pcjump(pcjump),
        .pc(pc), .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a few real instructions, then a bijective hash of the address
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h8C82_0004;
            32'h4:   return 32'hAC82_0008;
            32'h8:   return 32'h2042_0001;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOPW; m_pc4 = 32'h0; m_valid = 1'b0;
        m_hold = 1'b0; m_bi = 32'h0; m_bp = 32'h0;
    endtask

    // Advance the model one clock from the inputs currently driven
    task automatic model_step();
        logic [31:0] w;
        logic        busy;
        w = imem_word(m_pc);
        if (jump || pcsrc) begin
            m_pc = jump ? pcjump : pcbranch;
            m_instr = NOPW; m_valid = 1'b0; m_hold = 1'b0;
        end else begin
            busy = stall_d && !flush_d;
            if (!m_hold) begin
                if (imem_ready) begin
                    if (busy) begin
                        m_bi = w; m_bp = m_pc + 32'd4; m_hold = 1'b1;
                    end else begin
                        m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                    end
                    m_pc = m_pc + 32'd4;
                end else if (!busy) begin
                    m_instr = NOPW; m_valid = 1'b0;
                end
            end else if (!busy) begin
                m_instr = m_bi; m_pc4 = m_bp; m_valid = 1'b1; m_hold = 1'b0;
            end
            if (flush_d) begin
                m_instr = NOPW; m_valid = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample #1 after the next rising edge
    task automatic tick(input logic rdy, input logic st, input logic fl, input logic ps,
                        input logic [31:0] pb, input logic jp, input logic [31:0] pj);
        @(negedge clk);
        imem_ready = rdy; stall_d = st; flush_d = fl;
        pcsrc = ps; pcbranch = pb; jump = jp; pcjump = pj;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; imem_ready = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc = 1'b0; pcbranch = '0; jump = 1'b0; pcjump = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; imem_ready = 1'b1; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc = 1'b0; pcbranch = '0; jump = 1'b0; pcjump = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (pc !== 32'h0 || valid_d !== 1'b0 || instr_d !== NOPW || imem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d: pc=%h valid=%b instr=%h req=%b, want 0/0/0/0",
                         i, pc, valid_d, instr_d, imem_req);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (pc !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_release: pc=%h req=%b addr=%h, want 0/1/0", pc, imem_req, imem_addr);
        end
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (pc !== 32'(4 * i)) begin
                n_bad++;
                $display("FAIL reset_pc_step%0d: pc=%h want %h", i, pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_fetch_ops();
        logic [5:0] ops [3];
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_ADDI;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            n_cmp++;
            if (instr_d[31:26] !== ops[i] || valid_d !== 1'b1 || pc !== 32'(4 * (i + 1))
                || pcplus4_d !== 32'(4 * (i + 1))) begin
                n_bad++;
                $display("FAIL fetch_op%0d: op=%b valid=%b pc=%h pc4=%h, want op=%b valid=1 pc=pc4=%h",
                         i, instr_d[31:26], valid_d, pc, pcplus4_d, ops[i], 32'(4 * (i + 1)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            n_cmp++;
            if (instr_d !== 32'hAC82_0008 || valid_d !== 1'b1 || imem_req !== 1'b0 || pc !== 32'hC) begin
                n_bad++;
                $display("FAIL stall_hold%0d: instr=%h valid=%b req=%b pc=%h, want ac820008/1/0/c",
                         i, instr_d, valid_d, imem_req, pc);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (instr_d !== 32'h2042_0001 || pcplus4_d !== 32'hC || valid_d !== 1'b1
            || imem_req !== 1'b1 || pc !== 32'hC) begin
            n_bad++;
            $display("FAIL stall_release: instr=%h pc4=%h valid=%b req=%b pc=%h, want 20420001/c/1/1/c",
                     instr_d, pcplus4_d, valid_d, imem_req, pc);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (instr_d !== imem_word(32'hC) || pc !== 32'h10) begin
            n_bad++;
            $display("FAIL stall_next: instr=%h pc=%h, want %h/10", instr_d, pc, imem_word(32'hC));
        end
    endtask

    task automatic test_branch();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'd40, 1'b0, 32'h0);
        n_cmp++;
        if (pc !== 32'd40 || valid_d !== 1'b0 || instr_d !== NOPW) begin
            n_bad++;
            $display("FAIL branch_redirect: pc=%h valid=%b instr=%h, want 28/0/0", pc, valid_d, instr_d);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (instr_d !== imem_word(32'd40) || valid_d !== 1'b1 || pc !== 32'd44 || pcplus4_d !== 32'd44) begin
            n_bad++;
            $display("FAIL branch_target: instr=%h valid=%b pc=%h pc4=%h, want %h/1/2c/2c",
                     instr_d, valid_d, pc, pcplus4_d, imem_word(32'd40));
        end
    endtask

    task automatic test_jump();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'd40, 1'b1, 32'd80);
        n_cmp++;
        if (pc !== 32'd80 || valid_d !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_priority: pc=%h valid=%b, want 50/0", pc, valid_d);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (pc !== 32'd84 || imem_req !== 1'b0 || valid_d !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_enter_hold: pc=%h req=%b valid=%b, want 54/0/0", pc, imem_req, valid_d);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd80);
        n_cmp++;
        if (pc !== 32'd80 || imem_req !== 1'b1 || valid_d !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_in_hold: pc=%h req=%b valid=%b, want 50/1/0", pc, imem_req, valid_d);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (valid_d !== 1'b0 || imem_req !== 1'b1 || pc !== 32'd80) begin
            n_bad++;
            $display("FAIL jump_buf_dropped: valid=%b req=%b pc=%h, want 0/1/50", valid_d, imem_req, pc);
        end
    endtask

    task automatic test_flush();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (valid_d !== 1'b0 || instr_d !== NOPW || pc !== 32'h8 || imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_fetch: valid=%b instr=%h pc=%h req=%b, want 0/0/8/1",
                     valid_d, instr_d, pc, imem_req);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (valid_d !== 1'b0 || imem_req !== 1'b1 || pc !== 32'hC) begin
            n_bad++;
            $display("FAIL flush_hold: valid=%b req=%b pc=%h, want 0/1/c", valid_d, imem_req, pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (pc !== 32'h0 || pcplus4_d !== 32'h0 || instr_d !== imem_word(32'hFFFF_FFFC) || valid_d !== 1'b1) begin
            n_bad++;
            $display("FAIL pc_wrap: pc=%h pc4=%h instr=%h valid=%b, want 0/0/%h/1",
                     pc, pcplus4_d, instr_d, valid_d, imem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_cmp++;
        if (imem_addr !== 32'hC || imem_req !== 1'b1 || valid_d !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_pre: addr=%h req=%b valid=%b, want c/1/0", imem_addr, imem_req, valid_d);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 32'h0 || valid_d !== 1'b0 || instr_d !== NOPW || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async: pc=%h valid=%b instr=%h req=%b, want 0/0/0/0",
                     pc, valid_d, instr_d, imem_req);
        end
        @(negedge clk);
        reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_restart: req=%b addr=%h, want 1/0", imem_req, imem_addr);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (instr_d !== 32'h8C82_0004 || pc !== 32'h4) begin
            n_bad++;
            $display("FAIL reset_mid_first: instr=%h pc=%h, want 8c820004/4", instr_d, pc);
        end
    endtask

    task automatic test_random();
        logic        rdy, st, fl, ps, jp;
        logic [31:0] pb, pj;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 99) < 75);
            st  = ($urandom_range(0, 99) < 30);
            fl  = ($urandom_range(0, 99) < 8);
            ps  = ($urandom_range(0, 99) < 6);
            jp  = ($urandom_range(0, 99) < 4);
            pb  = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
            pj  = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            tick(rdy, st, fl, ps, pb, jp, pj);
            n_cmp++;
            if (pc !== m_pc || imem_addr !== m_pc) begin
                n_bad++;
                $display("FAIL rand_pc c%0d: pc=%h addr=%h want %h", c, pc, imem_addr, m_pc);
            end
            n_cmp++;
            if (imem_req !== !m_hold) begin
                n_bad++;
                $display("FAIL rand_req c%0d: req=%b want %b", c, imem_req, !m_hold);
            end
            n_cmp++;
            if (valid_d !== m_valid || instr_d !== m_instr) begin
                n_bad++;
                $display("FAIL rand_ifid c%0d: valid=%b instr=%h want %b/%h", c, valid_d, instr_d, m_valid, m_instr);
            end
            if (m_valid) begin
                n_cmp++;
                if (pcplus4_d !== m_pc4) begin
                    n_bad++;
                    $display("FAIL rand_pc4 c%0d: pc4=%h want %h", c, pcplus4_d, m_pc4);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc = 1'b0; pcbranch = '0; jump = 1'b0; pcjump = '0;
        model_reset();
        test_reset();
        test_fetch_ops();
        test_stall();
        test_branch();
        test_jump();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
